// File: rtl/boot_mem_pkg.sv
// rtl/boot_mem_pkg.sv - shared constants and state encoding for the boot/run/dump sequencer
package boot_mem_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int REGION_WORDS = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_CAP = 3'd4,
        ST_DUMP_OUT = 3'd5
    } state_t;

endpackage

// File: rtl/boot_mem_ctrl.sv
// rtl/boot_mem_ctrl.sv - owns the program RAM port and core reset: load, run with budget, dump
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_start/run_req/halt_req  host command pulses (accepted only in IDLE, halt only in RUN)
//   ld_valid/ld_ready/ld_data/ld_last  host load stream, written from address 0 upward
//   dump_start/dump_base/dump_len      dump command, len 0 = full 256-word region
//   dump_valid/dump_ready/dump_data    dump stream back to the host
//   cpu_rst                   registered core reset, low only in RUN
//   cpu_wrEn/cpu_addr/cpu_data  core RAM request, forwarded to the RAM in RUN
//   ram_we/ram_addr/ram_din   RAM port; ram_dout returns read data one clock later
//   busy, timeout, cyc_cnt    status: not IDLE, sticky budget expiry, clocks of last RUN
module boot_mem_ctrl
    import boot_mem_pkg::*;
#(
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          DATA_W     = DEF_DATA_W,
    parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              cpu_rst,
    input  logic              cpu_wrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              timeout,
    output logic [15:0]       cyc_cnt
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] base;
    // idx/count are one bit wider so a full-region dump (count = 256) is representable
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   idx_next;
    logic              budget_hit;

    assign idx_next = idx + {{ADDR_W{1'b0}}, 1'b1};

    // 17-bit compare so a saturated counter never aliases onto the budget
    assign budget_hit = (MAX_CYCLES != 16'd0) &&
                        (({1'b0, cyc_cnt} + 17'd1) == {1'b0, MAX_CYCLES});

    assign ld_ready   = (state == ST_LOAD);
    assign dump_valid = (state == ST_DUMP_OUT);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cpu_rst   <= 1'b1;
            ptr       <= '0;
            base      <= '0;
            idx       <= '0;
            count     <= '0;
            dump_data <= '0;
            timeout   <= 1'b0;
            cyc_cnt   <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        ptr   <= '0;
                        state <= ST_LOAD;
                    end else if (run_req) begin
                        cyc_cnt <= 16'd0;
                        timeout <= 1'b0;
                        cpu_rst <= 1'b0;
                        state   <= ST_RUN;
                    end else if (dump_start) begin
                        base  <= dump_base;
                        idx   <= '0;
                        count <= (dump_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                  : {1'b0, dump_len};
                        state <= ST_DUMP_RD;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ptr <= ptr + 1'b1;
                        if (ld_last || (ptr == {ADDR_W{1'b1}})) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cyc_cnt != 16'hFFFF) begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                    if (budget_hit) begin
                        timeout <= 1'b1;
                    end
                    if (halt_req || budget_hit) begin
                        cpu_rst <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_DUMP_RD: begin
                    state <= ST_DUMP_CAP;
                end
                ST_DUMP_CAP: begin
                    dump_data <= ram_dout;
                    state     <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (dump_ready) begin
                        idx   <= idx_next;
                        state <= (idx_next == count) ? ST_IDLE : ST_DUMP_RD;
                    end
                end
                default: begin
                    cpu_rst <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: loader writes, core pass-through, or dump read address
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            ST_LOAD: begin
                if (ld_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = ptr;
                    ram_din  = ld_data;
                end
            end
            ST_RUN: begin
                ram_we   = cpu_wrEn;
                ram_addr = cpu_addr;
                ram_din  = cpu_data;
            end
            ST_DUMP_RD: begin
                ram_addr = base + idx[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// tb/tb_boot_mem_ctrl.sv - randomized self-checking bench for boot_mem_ctrl against a memory-image model
module tb_boot_mem_ctrl;

    localparam int MAXC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, run_req, halt_req;
    logic        ld_valid, ld_ready, ld_last;
    logic [15:0] ld_data;
    logic        dump_start, dump_valid, dump_ready;
    logic [7:0]  dump_base, dump_len;
    logic [15:0] dump_data;
    logic        cpu_rst, cpu_wrEn;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        busy, timeout;
    logic [15:0] cyc_cnt;

    logic [15:0] ram [256];
    logic [15:0] ref_mem [256];
    logic [15:0] prog [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    boot_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .MAX_CYCLES(16'(MAXC))) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .run_req(run_req), .halt_req(halt_req),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .timeout(timeout), .cyc_cnt(cyc_cnt)
    );

    // external single-port RAM with one-clock read latency
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int nwords, input bit use_last, input bit fixed_prog);
        logic [15:0] w;
        logic [7:0]  ptr;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_cpu_rst", 32'(cpu_rst), 32'd1);
        ptr = 8'd0;
        for (int i = 0; i < nwords; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                #1 chk("load_gap_we", 32'(ram_we), 32'd0);
                tick();
            end
            w = fixed_prog ? prog[i] : 16'($urandom);
            ld_valid = 1'b1;
            ld_data  = w;
            ld_last  = use_last && (i == nwords - 1);
            #1 chk("load_wr", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, ptr, w}));
            ref_mem[ptr] = w;
            ptr = ptr + 8'd1;
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("load_exit_busy", 32'(busy), 32'd0);
        chk("load_exit_ready", 32'(ld_ready), 32'd0);
    endtask

    // hold_mode: 0 = always ready, 1 = random stalls, 2 = 4-clock stall on first word
    task automatic do_dump(input logic [7:0] base, input logic [7:0] len, input int hold_mode);
        int          n, lat, h;
        logic [7:0]  a;
        logic [15:0] exp_w;
        n = (len == 8'd0) ? 256 : int'(len);
        dump_start = 1'b1;
        dump_base  = base;
        dump_len   = len;
        tick();
        dump_start = 1'b0;
        dump_base  = 8'($urandom);
        dump_len   = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            lat = (k == 0) ? 1 : 0;
            while (!dump_valid && lat < 12) begin
                tick();
                lat++;
            end
            if (!dump_valid) begin
                chk("dump_valid_timeout", 32'(dump_valid), 32'd1);
                return;
            end
            if (k == 0) chk("dump_first_latency", 32'(lat), 32'd3);
            else        chk("dump_word_gap", 32'(lat), 32'd2);
            a     = base + 8'(k);
            exp_w = ref_mem[a];
            chk("dump_data", 32'(dump_data), 32'(exp_w));
            h = (hold_mode == 1) ? int'($urandom_range(0, 3)) :
                (hold_mode == 2 && k == 0) ? 4 : 0;
            for (int j = 0; j < h; j++) begin
                dump_ready = 1'b0;
                tick();
                chk("dump_hold_valid", 32'(dump_valid), 32'd1);
                chk("dump_hold_data", 32'(dump_data), 32'(exp_w));
            end
            dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
        end
        chk("dump_exit_busy", 32'(busy), 32'd0);
    endtask

    // halt_at = 0: no halt, rely on the budget
    task automatic do_run(input int halt_at);
        int cycles, exp_n;
        bit exp_to;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("run_entry_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_entry_cyc", 32'(cyc_cnt), 32'd0);
        chk("run_entry_timeout", 32'(timeout), 32'd0);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            cpu_wrEn = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom_range(16, 255));
            cpu_data = 16'($urandom);
            halt_req = (cycles == halt_at);
            if (cycles == 2) begin
                load_start = 1'b1;
                dump_start = 1'b1;
            end
            #1 chk("run_passthru", 32'({ram_we, ram_addr, ram_din}),
                   32'({cpu_wrEn, cpu_addr, cpu_data}));
            if (cpu_wrEn) ref_mem[cpu_addr] = cpu_data;
            tick();
            halt_req   = 1'b0;
            load_start = 1'b0;
            dump_start = 1'b0;
            cpu_wrEn   = 1'b0;
        end
        exp_n  = (halt_at > 0 && halt_at < MAXC) ? halt_at : MAXC;
        exp_to = (halt_at == 0 || halt_at >= MAXC);
        chk("run_cycles", 32'(cycles), 32'(exp_n));
        chk("run_cyc_cnt", 32'(cyc_cnt), 32'(exp_n));
        chk("run_timeout", 32'(timeout), 32'(exp_to));
        chk("run_exit_cpu_rst", 32'(cpu_rst), 32'd1);
    endtask

    initial begin
        int guard;
        prog[0] = 16'h7201;
        prog[1] = 16'h7403;
        prog[2] = 16'h0444;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        rst = 1'b1;
        load_start = 0; run_req = 0; halt_req = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0;
        dump_start = 0; dump_base = 0; dump_len = 0; dump_ready = 0;
        cpu_wrEn = 0; cpu_addr = 0; cpu_data = 0;
        tick();
        rst = 1'b0;

        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_data", 32'(dump_data), 32'd0);
        chk("rst_ram_port", 32'({ram_we, ram_addr, ram_din}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);

        do_load(3, 1'b1, 1'b1);
        do_dump(8'd0, 8'd3, 0);

        do_run(0);
        do_dump(8'd0, 8'd1, 0);
        chk("timeout_sticky", 32'(timeout), 32'd1);

        do_run(5);
        do_run(MAXC);

        // load_start wins over run_req and dump_start
        load_start = 1'b1; run_req = 1'b1; dump_start = 1'b1;
        tick();
        load_start = 1'b0; run_req = 1'b0; dump_start = 1'b0;
        chk("prio_load_ready", 32'(ld_ready), 32'd1);
        chk("prio_load_cpu_rst", 32'(cpu_rst), 32'd1);
        ld_valid = 1'b1; ld_data = 16'h7201; ld_last = 1'b1;
        tick();
        ref_mem[0] = 16'h7201;
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("prio_load_exit", 32'(busy), 32'd0);

        // run_req wins over dump_start
        run_req = 1'b1; dump_start = 1'b1;
        tick();
        run_req = 1'b0; dump_start = 1'b0;
        chk("prio_run_cpu_rst", 32'(cpu_rst), 32'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("prio_run_cyc", 32'(cyc_cnt), 32'd1);
        chk("prio_run_idle", 32'(busy), 32'd0);

        do_load(256, 1'b0, 1'b0);
        do_dump(8'hFE, 8'd0, 1);

        do_dump(8'h40, 8'd4, 2);

        for (int r = 0; r < 6; r++) begin
            do_load(int'($urandom_range(1, 20)), 1'b1, 1'b0);
            if (r % 2 == 1) do_run(int'($urandom_range(1, 25)));
            do_dump(8'($urandom), 8'($urandom_range(1, 8)), 1);
        end

        // reset in the middle of a dump
        dump_start = 1'b1; dump_base = 8'h00; dump_len = 8'd5;
        tick();
        dump_start = 1'b0;
        guard = 0;
        while (!dump_valid && guard < 10) begin
            tick();
            guard++;
        end
        chk("rstmid_dump_reached", 32'(dump_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_dump_valid", 32'(dump_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rstmid_dump_data", 32'(dump_data), 32'd0);

        // reset in the middle of a run
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("rstrun_cpu_rst_low", 32'(cpu_rst), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rstrun_cyc_cnt", 32'(cyc_cnt), 32'd0);
        chk("rstrun_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
